// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: default widths, PC type and reset vector.
package fetch_pkg;
    localparam int unsigned DEF_PC_W  = 16;
    localparam int unsigned DEF_TGT_W = 8;

    typedef logic [DEF_PC_W-1:0] pc_t;

    localparam pc_t PC_RESET = '0;
endpackage

// File: rtl/pc_reg.sv
// Program-counter register: async active-low reset, sync active-high clear.
module pc_reg
    import fetch_pkg::*;
#(
    parameter int unsigned W = DEF_PC_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= W'(PC_RESET);
        end else if (clr) begin
            q <= W'(PC_RESET);
        end else begin
            q <= d;
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch-stage PC datapath: increment, page-relative branch/jump, control reset.
// Optional macro INSTR_FETCH_XMASK_EN masks X/Z on accdata_in to "not taken".
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned PC_W  = DEF_PC_W,
    parameter int unsigned TGT_W = DEF_TGT_W
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic [TGT_W-1:0] dst_in,
    input  logic             reset_ctrl,
    input  logic             br_ctrl,
    input  logic             jmp_ctrl,
    input  logic             accdata_in,
    output logic [PC_W-1:0]  instr_addr
);
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_br;
    logic [PC_W-1:0] pc_next;
    logic            acc_ok;
    logic            br_sel;

    always_comb begin
`ifdef INSTR_FETCH_XMASK_EN
        acc_ok = (accdata_in === 1'b1);
`else
        acc_ok = accdata_in;
`endif
    end

    // Target page comes from PC+1, so a branch at xxFF lands on the next page.
    assign pc_inc  = instr_addr + PC_W'(1);
    assign pc_br   = {pc_inc[PC_W-1:TGT_W], dst_in};
    assign br_sel  = (br_ctrl & acc_ok) | jmp_ctrl;
    assign pc_next = br_sel ? pc_br : pc_inc;

    // reset_ctrl has top priority and is applied inside the register.
    pc_reg #(
        .W(PC_W)
    ) u_pc_reg (
        .clk  (CLK),
        .rst_n(reset_n),
        .clr  (reset_ctrl),
        .d    (pc_next),
        .q    (instr_addr)
    );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;
    logic        CLK;
    logic        reset_n;
    logic [7:0]  dst_in;
    logic        reset_ctrl;
    logic        br_ctrl;
    logic        jmp_ctrl;
    logic        accdata_in;
    logic [15:0] instr_addr;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(
        .PC_W (16),
        .TGT_W(8)
    ) dut (
        .CLK       (CLK),
        .reset_n   (reset_n),
        .dst_in    (dst_in),
        .reset_ctrl(reset_ctrl),
        .br_ctrl   (br_ctrl),
        .jmp_ctrl  (jmp_ctrl),
        .accdata_in(accdata_in),
        .instr_addr(instr_addr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        reset_n    = 1'b0;
        dst_in     = 8'h00;
        reset_ctrl = 1'b0;
        br_ctrl    = 1'b0;
        jmp_ctrl   = 1'b0;
        accdata_in = 1'b0;
        #1;
        check("reset_async", instr_addr, 16'h0000);
        step();
        step();
        check("reset_held", instr_addr, 16'h0000);

        reset_n = 1'b1;
        step(); check("count1", instr_addr, 16'h0001);
        step(); check("count2", instr_addr, 16'h0002);
        step(); check("count3", instr_addr, 16'h0003);
        step(); check("count4", instr_addr, 16'h0004);

        br_ctrl = 1'b1; accdata_in = 1'b1; dst_in = 8'h00;
        step(); check("br_taken", instr_addr, 16'h0000);
        br_ctrl = 1'b0; accdata_in = 1'b0;
        step(); check("after_br1", instr_addr, 16'h0001);
        step(); check("after_br2", instr_addr, 16'h0002);
        step();
        step(); check("back_at4", instr_addr, 16'h0004);

        br_ctrl = 1'b1; accdata_in = 1'b0; dst_in = 8'h20;
        step(); check("br_not_taken", instr_addr, 16'h0005);
        br_ctrl = 1'b0; jmp_ctrl = 1'b1;
        step(); check("jmp_acc0", instr_addr, 16'h0020);

        dst_in = 8'hFF;
        step(); check("jmp_to_ff", instr_addr, 16'h00FF);
        dst_in = 8'h10;
        step(); check("page_cross", instr_addr, 16'h0110);

        dst_in = 8'hFF;
        step(); check("jmp_01ff", instr_addr, 16'h01FF);
        for (int i = 0; i < 254; i++) step();
        check("reach_ffff", instr_addr, 16'hFFFF);
        jmp_ctrl = 1'b0;
        step(); check("wrap", instr_addr, 16'h0000);

        for (int i = 0; i < 7; i++) step();
        check("at7", instr_addr, 16'h0007);
        reset_ctrl = 1'b1; jmp_ctrl = 1'b1; dst_in = 8'h55;
        step(); check("rctl_over_jmp", instr_addr, 16'h0000);
        step(); check("rctl_hold", instr_addr, 16'h0000);
        reset_ctrl = 1'b0; jmp_ctrl = 1'b0;
        step(); check("rctl_resume", instr_addr, 16'h0001);
        step(); check("rctl_resume2", instr_addr, 16'h0002);

        #2;
        reset_n = 1'b0;
        #1;
        check("async_mid", instr_addr, 16'h0000);
        jmp_ctrl = 1'b1; dst_in = 8'h77;
        step(); check("async_wins", instr_addr, 16'h0000);
        jmp_ctrl = 1'b0;
        reset_n = 1'b1;
        step(); check("post_async", instr_addr, 16'h0001);

        br_ctrl = 1'b1; jmp_ctrl = 1'b1; accdata_in = 1'b1; dst_in = 8'h40;
        step(); check("br_and_jmp", instr_addr, 16'h0040);
        jmp_ctrl = 1'b0; accdata_in = 1'b0;
        step(); check("br_acc0_inc", instr_addr, 16'h0041);

`ifdef INSTR_FETCH_XMASK_EN
        accdata_in = 1'bx;
        step(); check("xmask_inc", instr_addr, 16'h0042);
`endif
        br_ctrl = 1'b0; accdata_in = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Program-counter datapath of the single-cycle core's fetch stage. Holds the 16-bit instruction address and updates it once per clock. The next address is one of: PC+1, a page-relative branch/jump target whose low byte comes from the `$dst` register, or zero on a control-driven reset. It drives the instruction-memory address and has no handshake.

## Interface
Parameters:
- `PC_W`, default 16: program-counter width.
- `TGT_W`, default 8: width of the low-byte target taken from `dst_in`. Must satisfy `TGT_W < PC_W`.

Ports:
- `CLK`, input, 1: sole clock, rising-edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `dst_in`, input, `TGT_W`: `$dst` register data, used as the low bits of the branch/jump target.
- `reset_ctrl`, input, 1: synchronous, active-high control reset of the PC to 0.
- `br_ctrl`, input, 1: conditional branch (`btr`). Taken only when `accdata_in` is 1.
- `jmp_ctrl`, input, 1: unconditional jump.
- `accdata_in`, input, 1: accumulator-equals-one flag, the branch condition.
- `instr_addr`, output, `PC_W`: current PC, driven directly from the register.

## Operation
- `pc_inc = instr_addr + 1`, modulo 2^`PC_W`, so 0xFFFF wraps to 0x0000.
- `pc_br = {pc_inc[PC_W-1:TGT_W], dst_in}`.
  - The upper bits come from PC+1, not PC.
  - At PC 0x00FF the target page is 0x01.
- `br_sel = (br_ctrl & accdata_in) | jmp_ctrl`.
- `pc_next` is selected in this priority order:
  1. `reset_ctrl` = 1 gives 0.
  2. Otherwise `br_sel` = 1 gives `pc_br`.
  3. Otherwise `pc_next` = `pc_inc`.
- `br_ctrl` and `jmp_ctrl` may both be high; the result is simply a taken transfer to `pc_br`.
- When `accdata_in` = 0, `br_ctrl` alone causes a plain increment.
- All next-PC logic is purely combinational. There is no state beyond the PC register.

## Timing
- `reset_n` low forces `instr_addr` = 0 immediately, independent of `CLK`.
- On the first rising edge after `reset_n` is released, the PC loads `pc_next` (normally 1).
- Each rising edge loads `pc_next`. Control inputs sampled at edge N take effect on `instr_addr` right after edge N, giving one cycle of latency.
- `reset_ctrl` asserted for k edges holds the PC at 0 for those edges. Counting resumes at 1 on the first edge after deassertion.
- If `reset_n` is asserted mid-operation, it wins over every other input.

## Configuration
- `INSTR_FETCH_XMASK_EN` defined:
  - An `accdata_in` value of X or Z is treated as 0 inside `br_sel`, so an uninitialised accumulator never causes a branch.
  - This masking is for simulation only and synthesises to the plain AND.
- `INSTR_FETCH_XMASK_EN` undefined: `accdata_in` is used as-is, and X propagates into `pc_next`.

## Structure
- Shared package `fetch_pkg` holds:
  - `PC_W`/`TGT_W` defaults.
  - The `pc_t` typedef (`logic [PC_W-1:0]`).
  - The reset-vector constant `PC_RESET = '0`.
- One natural sub-module, `pc_reg`: the PC register with async `reset_n` and sync `reset_ctrl`.
  - The incrementer, target concatenation and 2:1 select stay inline in the top.

## Test plan
- Reset and count: hold `reset_n` low, then release with all controls 0. Required: `instr_addr` = 0 during reset, then 1, 2, 3, 4 on successive edges.
- Taken branch: at PC 4 with `br_ctrl`=1, `accdata_in`=1, `dst_in`=0x00. Required: next PC is 0x0000. Deasserting `br_ctrl` then gives 1, 2.
- Not-taken branch and jump: at PC 4 with `br_ctrl`=1, `accdata_in`=0, `dst_in`=0x20. Required: next PC is 5. Then set `jmp_ctrl`=1 with `accdata_in`=0. Required: next PC is 0x0020.
- Page boundary: drive the PC to 0x00FF via jump with `dst_in`=0xFF, then jump with `dst_in`=0x10. Required: next PC is 0x0110.
- Wrap and priority:
  - Free-run to 0xFFFF. Required: next PC is 0x0000.
  - At PC 7 assert `reset_ctrl` together with `jmp_ctrl`. Required: next PC is 0.
  - Assert `reset_n` low between edges. Required: `instr_addr` is 0 immediately.
- X masking, with `INSTR_FETCH_XMASK_EN` defined: `br_ctrl`=1 and `accdata_in`=X. Required: the PC increments normally.
